// File: rtl/jtag_debug_sys_mem_arbiter.sv
// Two-master arbiter in front of a single-port RAM with 1-cycle read latency.
// Master 0 and master 1 share the RAM. When both keep requesting, ownership
// rotates after MAX_BURST consecutive grants. Grant is combinational from the
// requests and the registered ownership state. Read data is broadcast to both
// masters, and only readdatavalid is steered back to the master that issued
// the read.
module jtag_debug_sys_mem_arbiter #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic                clk,
    input  logic                reset_n,

    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,

    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,

    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata
);

    localparam int BE_W = DATA_W / 8;
    // Four bits covers the whole legal burst range of 1..15.
    localparam logic [3:0] MAX_BURST_C = 4'(MAX_BURST);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        last_q, last_d;         // master granted most recently
    logic [3:0]  cnt_q, cnt_d;           // consecutive grants to current owner
    logic        rd_pending_q, rd_pending_d;
    logic        rd_owner_q, rd_owner_d;

    logic        req0_s, req1_s;
    logic        gnt0_s, gnt1_s;
    logic [1:0]  pick_s;                 // {gnt1, gnt0} from fair arbitration

    // Fair pick used when no owner keeps the bus.
    // A lone requester wins. On a tie, the master that did not own last wins.
    function automatic logic [1:0] fair_pick(input logic r0, input logic r1,
                                             input logic last);
        logic [1:0] g;
        if (r0 && r1) begin
            if (last) begin
                g = 2'b01;
            end else begin
                g = 2'b10;
            end
        end else if (r0) begin
            g = 2'b01;
        end else if (r1) begin
            g = 2'b10;
        end else begin
            g = 2'b00;
        end
        return g;
    endfunction

    // Burst counter increment that stops at MAX_BURST.
    function automatic logic [3:0] sat_inc(input logic [3:0] c);
        logic [3:0] n;
        if (c >= MAX_BURST_C) begin
            n = MAX_BURST_C;
        end else begin
            n = c + 4'd1;
        end
        return n;
    endfunction

    // A write takes priority when read and write are both high, so either strobe is a request.
    assign req0_s = m0_read | m0_write;
    assign req1_s = m1_read | m1_write;

    // Grant decision.
    // The owner keeps the bus until its burst limit is reached while the other
    // master waits. If the owner stops requesting, the other master is picked
    // in the same cycle. No grant is issued while reset is asserted.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        pick_s = fair_pick(req0_s, req1_s, last_q);
        if (!reset_n) begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end else begin
            case (state_q)
                ST_OWN0: begin
                    if (req0_s) begin
                        if ((cnt_q < MAX_BURST_C) || !req1_s) begin
                            gnt0_s = 1'b1;
                        end else begin
                            gnt1_s = 1'b1;
                        end
                    end else begin
                        gnt0_s = pick_s[0];
                        gnt1_s = pick_s[1];
                    end
                end
                ST_OWN1: begin
                    if (req1_s) begin
                        if ((cnt_q < MAX_BURST_C) || !req0_s) begin
                            gnt1_s = 1'b1;
                        end else begin
                            gnt0_s = 1'b1;
                        end
                    end else begin
                        gnt0_s = pick_s[0];
                        gnt1_s = pick_s[1];
                    end
                end
                ST_IDLE: begin
                    gnt0_s = pick_s[0];
                    gnt1_s = pick_s[1];
                end
                default: begin
                    gnt0_s = pick_s[0];
                    gnt1_s = pick_s[1];
                end
            endcase
        end
    end

    // Next ownership, burst count and read-pending tracking.
    // The count restarts at 1 whenever ownership moves to a different master.
    always_comb begin
        state_d      = ST_IDLE;
        last_d       = last_q;
        cnt_d        = 4'd0;
        rd_pending_d = 1'b0;
        rd_owner_d   = rd_owner_q;
        if (gnt0_s) begin
            state_d      = ST_OWN0;
            last_d       = 1'b0;
            cnt_d        = (state_q == ST_OWN0) ? sat_inc(cnt_q) : 4'd1;
            rd_pending_d = m0_read & ~m0_write;
            rd_owner_d   = 1'b0;
        end else if (gnt1_s) begin
            state_d      = ST_OWN1;
            last_d       = 1'b1;
            cnt_d        = (state_q == ST_OWN1) ? sat_inc(cnt_q) : 4'd1;
            rd_pending_d = m1_read & ~m1_write;
            rd_owner_d   = 1'b1;
        end else begin
            state_d      = ST_IDLE;
            cnt_d        = 4'd0;
            rd_pending_d = 1'b0;
        end
    end

    // Arbitration state registers.
    // Reset clears any in-flight read, so its readdatavalid is dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            last_q       <= 1'b1;
            cnt_q        <= 4'd0;
            rd_pending_q <= 1'b0;
            rd_owner_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            cnt_q        <= cnt_d;
            rd_pending_q <= rd_pending_d;
            rd_owner_q   <= rd_owner_d;
        end
    end

    // Route the granted master onto the RAM port.
    // The bus is quiet when nobody is granted.
    always_comb begin
        mem_address    = {ADDR_W{1'b0}};
        mem_byteenable = {BE_W{1'b0}};
        mem_writedata  = {DATA_W{1'b0}};
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        if (gnt0_s) begin
            mem_address    = m0_address;
            mem_byteenable = m0_byteenable;
            mem_writedata  = m0_writedata;
            mem_chipselect = 1'b1;
            mem_write      = m0_write;
        end else if (gnt1_s) begin
            mem_address    = m1_address;
            mem_byteenable = m1_byteenable;
            mem_writedata  = m1_writedata;
            mem_chipselect = 1'b1;
            mem_write      = m1_write;
        end else begin
            mem_chipselect = 1'b0;
            mem_write      = 1'b0;
        end
    end

    assign mem_clken        = 1'b1;
    assign m0_waitrequest   = ~gnt0_s;
    assign m1_waitrequest   = ~gnt1_s;
    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;
    assign m0_readdatavalid = rd_pending_q & ~rd_owner_q;
    assign m1_readdatavalid = rd_pending_q &  rd_owner_q;

endmodule

// File: tb/tb_jtag_debug_sys_mem_arbiter.sv
// Directed bench for jtag_debug_sys_mem_arbiter with a behavioural single-port RAM.
module tb_jtag_debug_sys_mem_arbiter;

    logic        clk;
    logic        reset_n;
    logic [9:0]  m0_address, m1_address;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic [9:0]  mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;

    logic        init_mem;
    logic [31:0] ram [0:1023];

    int checks = 0;
    int passed = 0;

    jtag_debug_sys_mem_arbiter #(.ADDR_W(10), .DATA_W(32), .MAX_BURST(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable),
        .m0_read(m0_read), .m0_write(m0_write), .m0_writedata(m0_writedata),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable),
        .m1_read(m1_read), .m1_write(m1_write), .m1_writedata(m1_writedata),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken),
        .mem_readdata(mem_readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: registered address, data valid the cycle after a read.
    // Every word is preloaded with 0xC0DE0000 | address.
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 1024; i++) ram[i] <= 32'hC0DE0000 | 32'(i);
        end else if (mem_chipselect && mem_clken) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            end else begin
                mem_readdata <= ram[mem_address];
            end
        end
    end

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        checks = checks + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic chk_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic drv_m0(input logic rd, input logic wr, input logic [9:0] a,
                          input logic [3:0] be, input logic [31:0] wd);
        m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = wd;
    endtask

    task automatic drv_m1(input logic rd, input logic wr, input logic [9:0] a,
                          input logic [3:0] be, input logic [31:0] wd);
        m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = wd;
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk_bit({tag, "_m0_wait"}, m0_waitrequest, 1'b1);
        chk_bit({tag, "_m1_wait"}, m1_waitrequest, 1'b1);
        chk_bit({tag, "_m0_rdv"}, m0_readdatavalid, 1'b0);
        chk_bit({tag, "_m1_rdv"}, m1_readdatavalid, 1'b0);
        chk_bit({tag, "_cs"}, mem_chipselect, 1'b0);
        chk_bit({tag, "_wr"}, mem_write, 1'b0);
    endtask

    initial begin
        logic exp_g0;
        reset_n  = 1'b0;
        init_mem = 1'b1;
        // Requests are active during reset; they must have no effect.
        drv_m0(1'b0, 1'b1, 10'h001, 4'hF, 32'h0);
        drv_m1(1'b1, 1'b0, 10'h002, 4'hF, 32'h0);
        tick();
        tick();
        chk_reset_outputs("rst");
        chk_bit("clken", mem_clken, 1'b1);

        reset_n  = 1'b1;
        init_mem = 1'b0;
        drv_m0(1'b0, 1'b0, 10'h0, 4'h0, 32'h0);
        drv_m1(1'b0, 1'b0, 10'h0, 4'h0, 32'h0);
        #1;
        chk_bit("idle_m0_wait", m0_waitrequest, 1'b1);
        chk_bit("idle_cs", mem_chipselect, 1'b0);

        // Simultaneous reads after reset: m0 wins, m1 follows once m0 drops.
        tick();
        drv_m0(1'b1, 1'b0, 10'h005, 4'hF, 32'h0);
        drv_m1(1'b1, 1'b0, 10'h006, 4'hF, 32'h0);
        #1;
        chk_bit("both_m0_wait", m0_waitrequest, 1'b0);
        chk_bit("both_m1_wait", m1_waitrequest, 1'b1);
        chk_word("both_addr", {22'b0, mem_address}, 32'h005);
        chk_bit("both_cs", mem_chipselect, 1'b1);
        tick();
        chk_bit("both_m0_rdv", m0_readdatavalid, 1'b1);
        chk_bit("both_m1_rdv0", m1_readdatavalid, 1'b0);
        chk_word("both_m0_data", m0_readdata, 32'hC0DE0005);
        m0_read = 1'b0;
        #1;
        chk_bit("m1_after_wait", m1_waitrequest, 1'b0);
        chk_word("m1_after_addr", {22'b0, mem_address}, 32'h006);
        tick();
        chk_bit("m1_after_rdv", m1_readdatavalid, 1'b1);
        chk_bit("m1_after_m0rdv", m0_readdatavalid, 1'b0);
        chk_word("m1_after_data", m1_readdata, 32'hC0DE0006);
        m1_read = 1'b0;
        tick();
        chk_bit("drain_m0_rdv", m0_readdatavalid, 1'b0);
        chk_bit("drain_m1_rdv", m1_readdatavalid, 1'b0);

        // Continuous contention: 4 grants to m0, 4 to m1, then back to m0.
        drv_m0(1'b1, 1'b0, 10'h00A, 4'hF, 32'h0);
        drv_m1(1'b1, 1'b0, 10'h014, 4'hF, 32'h0);
        for (int c = 0; c < 10; c++) begin
            exp_g0 = (c < 4) || (c >= 8);
            #1;
            chk_bit($sformatf("burst%0d_m0_wait", c), m0_waitrequest, ~exp_g0);
            chk_bit($sformatf("burst%0d_m1_wait", c), m1_waitrequest, exp_g0);
            tick();
            chk_bit($sformatf("burst%0d_m0_rdv", c), m0_readdatavalid, exp_g0);
            chk_bit($sformatf("burst%0d_m1_rdv", c), m1_readdatavalid, ~exp_g0);
            chk_word($sformatf("burst%0d_data", c), m0_readdata,
                     exp_g0 ? 32'hC0DE000A : 32'hC0DE0014);
        end
        m0_read = 1'b0;
        m1_read = 1'b0;
        tick();

        // m1 writes 0xDEADBEEF to 0x3FF, m0 reads it back.
        drv_m1(1'b0, 1'b1, 10'h3FF, 4'hF, 32'hDEADBEEF);
        #1;
        chk_bit("wr1_m1_wait", m1_waitrequest, 1'b0);
        chk_bit("wr1_mem_write", mem_write, 1'b1);
        chk_word("wr1_addr", {22'b0, mem_address}, 32'h3FF);
        chk_word("wr1_wdata", mem_writedata, 32'hDEADBEEF);
        tick();
        chk_bit("wr1_no_rdv1", m1_readdatavalid, 1'b0);
        chk_bit("wr1_no_rdv0", m0_readdatavalid, 1'b0);
        drv_m1(1'b0, 1'b0, 10'h0, 4'h0, 32'h0);
        drv_m0(1'b1, 1'b0, 10'h3FF, 4'hF, 32'h0);
        #1;
        chk_bit("rd3ff_m0_wait", m0_waitrequest, 1'b0);
        tick();
        chk_bit("rd3ff_rdv", m0_readdatavalid, 1'b1);
        chk_word("rd3ff_data", m0_readdata, 32'hDEADBEEF);
        chk_word("rd3ff_m1_data", m1_readdata, 32'hDEADBEEF);
        chk_bit("rd3ff_m1_rdv", m1_readdatavalid, 1'b0);

        // Partial byte write; the second write also raises read (write wins).
        drv_m0(1'b0, 1'b1, 10'h040, 4'hF, 32'hFFFFFFFF);
        tick();
        drv_m0(1'b1, 1'b1, 10'h040, 4'h5, 32'h11223344);
        #1;
        chk_bit("be_wr_mem_write", mem_write, 1'b1);
        chk_word("be_wr_be", {28'b0, mem_byteenable}, 32'h5);
        tick();
        chk_bit("be_wr_no_rdv", m0_readdatavalid, 1'b0);
        drv_m0(1'b1, 1'b0, 10'h040, 4'hF, 32'h0);
        tick();
        chk_bit("be_rd_rdv", m0_readdatavalid, 1'b1);
        chk_word("be_rd_data", m0_readdata, 32'hFF22FF44);

        // Alternating reads m0@1, m1@2, m0@3 with no gaps.
        drv_m0(1'b1, 1'b0, 10'h001, 4'hF, 32'h0);
        tick();
        chk_bit("alt0_m0_rdv", m0_readdatavalid, 1'b1);
        chk_word("alt0_data", m0_readdata, 32'hC0DE0001);
        m0_read = 1'b0;
        drv_m1(1'b1, 1'b0, 10'h002, 4'hF, 32'h0);
        tick();
        chk_bit("alt1_m1_rdv", m1_readdatavalid, 1'b1);
        chk_bit("alt1_m0_rdv", m0_readdatavalid, 1'b0);
        chk_word("alt1_data", m1_readdata, 32'hC0DE0002);
        m1_read = 1'b0;
        drv_m0(1'b1, 1'b0, 10'h003, 4'hF, 32'h0);
        tick();
        chk_bit("alt2_m0_rdv", m0_readdatavalid, 1'b1);
        chk_bit("alt2_m1_rdv", m1_readdatavalid, 1'b0);
        chk_word("alt2_data", m0_readdata, 32'hC0DE0003);
        m0_read = 1'b0;
        tick();
        chk_bit("alt3_m0_rdv", m0_readdatavalid, 1'b0);
        chk_bit("alt3_m1_rdv", m1_readdatavalid, 1'b0);

        // Reset in the cycle after a read grant drops the pending readdatavalid.
        drv_m0(1'b1, 1'b0, 10'h007, 4'hF, 32'h0);
        #1;
        chk_bit("rr_grant", m0_waitrequest, 1'b0);
        @(posedge clk);
        reset_n = 1'b0;
        drv_m1(1'b0, 1'b1, 10'h008, 4'hF, 32'h0);
        #1;
        chk_reset_outputs("rr_now");
        tick();
        chk_reset_outputs("rr_hold");
        reset_n = 1'b1;
        drv_m1(1'b1, 1'b0, 10'h008, 4'hF, 32'h0);
        #1;
        chk_bit("rr_post_m0_wait", m0_waitrequest, 1'b0);
        chk_bit("rr_post_m1_wait", m1_waitrequest, 1'b1);
        tick();
        chk_bit("rr_post_rdv", m0_readdatavalid, 1'b1);
        chk_word("rr_post_data", m0_readdata, 32'hC0DE0007);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/jtag_debug_sys_mem_arbiter.md
JTAG_DEBUG_SYS_MEM_ARBITER -- requirements
Module: jtag_debug_sys_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, memory word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width; byteenable width is DATA_W/8.
REQ-003 SHALL have parameter MAX_BURST, default 4, legal range 1..15; the maximum number of consecutive grants to one master while the other master waits.
REQ-004 SHALL have ports, with one clock; reset is asynchronous and active-low:
  clk  in  1  clock
  reset_n  in  1  asynchronous active-low reset
  m0_address / m1_address  in  ADDR_W  word address
  m0_byteenable / m1_byteenable  in  DATA_W/8  byte lanes
  m0_read / m1_read  in  1  read request
  m0_write / m1_write  in  1  write request
  m0_writedata / m1_writedata  in  DATA_W  write data
  m0_waitrequest / m1_waitrequest  out  1  transfer not accepted this cycle
  m0_readdata / m1_readdata  out  DATA_W  read data
  m0_readdatavalid / m1_readdatavalid  out  1  readdata valid
  mem_address  out  ADDR_W  to the single-port RAM
  mem_byteenable  out  DATA_W/8  to RAM
  mem_chipselect  out  1  to RAM
  mem_write  out  1  to RAM
  mem_writedata  out  DATA_W  to RAM
  mem_clken  out  1  RAM clock enable, tied to 1
  mem_readdata  in  DATA_W  RAM unregistered q; valid the cycle after the address is presented

Function
REQ-005 SHALL define req_k = mk_read | mk_write; when both are high, the transfer is a write and the read is ignored.
REQ-006 SHALL grant at most one master per cycle; grant is combinational from the requests and the registered state.
REQ-007 SHALL keep state IDLE, OWN0 or OWN1, a last-owner bit (reset 1), and a grant counter cnt (0..MAX_BURST, saturating).
REQ-008 In IDLE, a single requester SHALL be granted; with both requesting, the master other than last-owner SHALL be granted.
REQ-009 In OWNk, if req_k and (cnt < MAX_BURST or no req from the other master), the arbiter SHALL grant k and increment cnt (saturating).
REQ-010 In OWNk, if req_k, cnt == MAX_BURST and the other master requests, the arbiter SHALL grant the other master that cycle.
REQ-011 In OWNk, if req_k is low, the arbiter SHALL arbitrate as in IDLE in the same cycle, with no idle bubble.
REQ-012 On any grant to master j, the next state SHALL be OWNj and last-owner SHALL be j; cnt SHALL become 1 when ownership changes, otherwise cnt+1. With no grant, the next state SHALL be IDLE and cnt 0.
REQ-013 mk_waitrequest SHALL equal NOT grant_k; it is therefore high whenever master k is not granted, including when it is idle.
REQ-014 For the granted master, the arbiter SHALL drive mem_chipselect=1, mem_write=mk_write, and mem_address/byteenable/writedata from master k. With no grant, mem_chipselect=0 and mem_write=0.
REQ-015 A granted read SHALL set a registered rd_pending=1 and rd_owner=k; in the next cycle mk_readdatavalid SHALL be 1 for exactly one cycle, giving 1-cycle read latency.
REQ-016 Back-to-back reads, including reads from alternating masters, SHALL each return exactly once, in order, with no lost or duplicated readdatavalid.
REQ-017 m0_readdata and m1_readdata SHALL both be driven from mem_readdata; only readdatavalid is steered.
REQ-018 A write SHALL complete in its grant cycle and SHALL produce no readdatavalid.

Reset
REQ-019 While reset_n=0, the arbiter SHALL hold state IDLE, last-owner 1, cnt 0, rd_pending 0, m0/m1_waitrequest 1, m0/m1_readdatavalid 0, mem_chipselect 0 and mem_write 0, regardless of requests.
REQ-020 An assertion of reset_n mid-read SHALL discard the pending readdatavalid; the first grant after deassertion SHALL follow REQ-008.

Verification
REQ-021 The bench SHALL cover: after reset, both masters read at once -> m0 granted first (m1_waitrequest=1); m0_readdatavalid pulses the next cycle; m1 granted the cycle after if m0 has dropped its request.
REQ-022 The bench SHALL cover: m0 requests continuously, m1 requests from cycle 0, MAX_BURST=4 -> grants are m0,m0,m0,m0,m1,...; m1 gets no more than 4 consecutive grants while m0 waits.
REQ-023 The bench SHALL cover: m1 writes 0xDEADBEEF to address 0x3FF with byteenable 0xF, then m0 reads 0x3FF -> m0_readdata=0xDEADBEEF with m0_readdatavalid one cycle after the m0 grant.
REQ-024 The bench SHALL cover: m0 writes 0x11223344 with byteenable 0x5 over 0xFFFFFFFF -> a readback gives 0xFF22FF44.
REQ-025 The bench SHALL cover: alternating reads m0@1, m1@2, m0@3 with no gaps -> readdatavalid on m0,m1,m0 in consecutive cycles, with correct data.
REQ-026 The bench SHALL cover: reset_n driven low in the cycle after a read grant -> no readdatavalid; all outputs take their REQ-019 values immediately.
